// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control sequencer for the single-bus CPU datapath
//
// Purpose:
//   Steps the datapath through fetch (T0-T2) and execute (T3-T6). It asserts
//   one-hot bus-drive strobes, register-load strobes and a one-hot ALU
//   operation word for each step.
//
// Ports:
//   clk, clr          clock; synchronous active-high reset
//   ir                current IR (opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15])
//   mem_ready         memory read data valid (only consulted in T1)
//   PCout..Cout       bus-drive strobes (at most one, including reg_out, per cycle)
//   PCin..LOin        register-load strobes
//   IncPC, MDRRead    ALU PC+1 request, MDR source select
//   reg_out, reg_in   one-hot general register bus-drive / load
//   ALUControl        one-hot ALU operation
//   run, illegal_op   not-halted flag, unsupported-opcode pulse
//   step              (STEP_MODE_EN only) start the next instruction from IDLE
//
// Optional feature macro: STEP_MODE_EN
//   When it is defined, the sequencer parks in IDLE after reset and after each
//   completed instruction. It leaves IDLE only when step is sampled high.

module control_sequencer #(
  parameter int NREGS = 16,
  parameter int ALUW  = 12
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
`ifdef STEP_MODE_EN
  input  logic             step,
`endif
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             Cout,
  output logic             PCin,
  output logic             MARin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             MDRRead,
  output logic [NREGS-1:0] reg_out,
  output logic [NREGS-1:0] reg_in,
  output logic [ALUW-1:0]  ALUControl,
  output logic             run,
  output logic             illegal_op
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
`ifdef STEP_MODE_EN
    S_IDLE,
`endif
    S_HALT
  } state_e;

`ifdef STEP_MODE_EN
  localparam state_e DONE_STATE = S_IDLE;
`else
  localparam state_e DONE_STATE = S_T0;
`endif

  state_e state_q;
  // Set once the first T1 cycle has passed, so PC increments only once per fetch.
  logic   pc_done_q;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_r, is_i, is_md, is_un, is_nop, is_halt, is_ill;
  logic [ALUW-1:0] alu_sel;
  logic       unused_ir_low;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir_low = ^ir[14:0];

  function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    is_r    = 1'b0;
    is_i    = 1'b0;
    is_md   = 1'b0;
    is_un   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    alu_sel = '0;
    case (op)
      5'd3:  begin is_r  = 1'b1; alu_sel[0]  = 1'b1; end
      5'd4:  begin is_r  = 1'b1; alu_sel[1]  = 1'b1; end
      5'd5:  begin is_r  = 1'b1; alu_sel[2]  = 1'b1; end
      5'd6:  begin is_r  = 1'b1; alu_sel[3]  = 1'b1; end
      5'd7:  begin is_r  = 1'b1; alu_sel[4]  = 1'b1; end
      5'd9:  begin is_r  = 1'b1; alu_sel[5]  = 1'b1; end
      5'd10: begin is_r  = 1'b1; alu_sel[6]  = 1'b1; end
      5'd11: begin is_r  = 1'b1; alu_sel[7]  = 1'b1; end
      5'd12: begin is_i  = 1'b1; alu_sel[0]  = 1'b1; end
      5'd13: begin is_i  = 1'b1; alu_sel[2]  = 1'b1; end
      5'd14: begin is_i  = 1'b1; alu_sel[3]  = 1'b1; end
      5'd15: begin is_md = 1'b1; alu_sel[8]  = 1'b1; end
      5'd16: begin is_md = 1'b1; alu_sel[9]  = 1'b1; end
      5'd17: begin is_un = 1'b1; alu_sel[10] = 1'b1; end
      5'd18: begin is_un = 1'b1; alu_sel[11] = 1'b1; end
      5'd27: is_nop  = 1'b1;
      5'd28: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_ill = !(is_r || is_i || is_md || is_un || is_nop || is_halt);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= DONE_STATE;
      pc_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_T0: begin
          state_q   <= S_T1;
          pc_done_q <= 1'b0;
        end
        S_T1: begin
          pc_done_q <= 1'b1;
          if (mem_ready) state_q <= S_T2;
        end
        S_T2: state_q <= S_T3;
        S_T3: begin
          if (is_halt)                           state_q <= S_HALT;
          else if (is_r || is_i || is_md || is_un) state_q <= S_T4;
          else                                   state_q <= DONE_STATE;
        end
        S_T4: state_q <= is_un ? DONE_STATE : S_T5;
        S_T5: state_q <= is_md ? S_T6 : DONE_STATE;
        S_T6: state_q <= DONE_STATE;
        S_HALT: state_q <= S_HALT;
`ifdef STEP_MODE_EN
        S_IDLE: if (step) state_q <= S_T0;
`endif
        default: state_q <= DONE_STATE;
      endcase
    end
  end

  // Outputs decode the registered state plus ir; clr masks everything so the
  // datapath sees no strobes while reset is held.
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    Cout       = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    MDRRead    = 1'b0;
    reg_out    = '0;
    reg_in     = '0;
    ALUControl = '0;
    run        = 1'b1;
    illegal_op = 1'b0;
    if (!clr) begin
      run = (state_q != S_HALT);
      case (state_q)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = !pc_done_q; MDRRead = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          if (is_md) begin
            reg_out = reg_sel(ra); Yin = 1'b1;
          end else if (is_r || is_i) begin
            reg_out = reg_sel(rb); Yin = 1'b1;
          end else if (is_un) begin
            reg_out = reg_sel(rb); ALUControl = alu_sel; Zin = 1'b1;
          end else if (is_ill) begin
            illegal_op = 1'b1;
          end
        end
        S_T4: begin
          if (is_r) begin
            reg_out = reg_sel(rc); ALUControl = alu_sel; Zin = 1'b1;
          end else if (is_i) begin
            Cout = 1'b1; ALUControl = alu_sel; Zin = 1'b1;
          end else if (is_md) begin
            reg_out = reg_sel(rb); ALUControl = alu_sel; Zin = 1'b1;
          end else if (is_un) begin
            Zlowout = 1'b1; reg_in = reg_sel(ra);
          end
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (is_md) LOin = 1'b1;
          else       reg_in = reg_sel(ra);
        end
        S_T6: begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized model-checked bench for control_sequencer

module tb_control_sequencer;

  typedef struct packed {
    logic pcout, zlo, zhi, mdrout, hiout, loout, cout;
    logic pcin, marin, mdrin, irin, yin, zin, hiin, loin;
    logic incpc, mdrread;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [11:0] alu;
    logic run, ill;
  } exp_t;

  typedef struct {
    exp_t        e;
    logic [31:0] ir;
    logic        mr;
    logic        clr;
  } cyc_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, MDRRead;
  logic [15:0] reg_out, reg_in;
  logic [11:0] ALUControl;
  logic run, illegal_op;

  int checks = 0;
  int errors = 0;
  cyc_t q[$];
  exp_t cur_exp;
  exp_t act;
  logic chk_en = 1'b0;
  string cur_name = "reset";

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .MDRRead(MDRRead),
    .reg_out(reg_out), .reg_in(reg_in), .ALUControl(ALUControl),
    .run(run), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  always_comb begin
    act = '{PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
            PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
            IncPC, MDRRead, reg_out, reg_in, ALUControl, run, illegal_op};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act !== cur_exp) begin
        errors++;
        $display("FAIL %s t=%0t got %h want %h", cur_name, $time, act, cur_exp);
      end
    end
  end

  // 0 R-type, 1 I-type, 2 mul/div, 3 neg/not, 4 nop, 5 halt, 6 illegal
  function automatic int op_class(input logic [4:0] op);
    if ((op >= 3 && op <= 7) || (op >= 9 && op <= 11)) return 0;
    if (op >= 12 && op <= 14) return 1;
    if (op == 15 || op == 16) return 2;
    if (op == 17 || op == 18) return 3;
    if (op == 27) return 4;
    if (op == 28) return 5;
    return 6;
  endfunction

  function automatic logic [11:0] alu_word(input logic [4:0] op);
    int idx;
    case (op)
      3, 12: idx = 0;
      4:     idx = 1;
      5, 13: idx = 2;
      6, 14: idx = 3;
      7:     idx = 4;
      9:     idx = 5;
      10:    idx = 6;
      11:    idx = 7;
      15:    idx = 8;
      16:    idx = 9;
      17:    idx = 10;
      18:    idx = 11;
      default: idx = -1;
    endcase
    return (idx < 0) ? 12'h000 : (12'h001 << idx);
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input logic [31:0] irv, input logic mr, input logic c);
    cyc_t cy;
    cy.e = e; cy.ir = irv; cy.mr = mr; cy.clr = c;
    q.push_back(cy);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(blank(), $urandom, 1'($urandom), 1'b1);
  endtask

  // Whole-instruction expectation: fetch with nwait stalled T1 cycles, then execute.
  task automatic add_instr(input logic [31:0] iv, input int nwait);
    exp_t e;
    logic [4:0]  op;
    logic [15:0] ra1, rb1, rc1;
    op  = iv[31:27];
    ra1 = 16'h0001 << iv[26:23];
    rb1 = 16'h0001 << iv[22:19];
    rc1 = 16'h0001 << iv[18:15];
    e = blank(); e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    push(e, $urandom, 1'($urandom), 1'b0);
    for (int k = 0; k <= nwait; k++) begin
      e = blank(); e.zlo = 1; e.mdrread = 1; e.mdrin = 1; e.pcin = (k == 0);
      push(e, $urandom, (k == nwait), 1'b0);
    end
    e = blank(); e.mdrout = 1; e.irin = 1;
    push(e, $urandom, 1'($urandom), 1'b0);
    case (op_class(op))
      0, 1: begin
        e = blank(); e.rout = rb1; e.yin = 1; push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.alu = alu_word(op); e.zin = 1;
        if (op_class(op) == 0) e.rout = rc1; else e.cout = 1;
        push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.zlo = 1; e.rin = ra1; push(e, iv, 1'($urandom), 1'b0);
      end
      2: begin
        e = blank(); e.rout = ra1; e.yin = 1; push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.rout = rb1; e.alu = alu_word(op); e.zin = 1;
        push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.zlo = 1; e.loin = 1; push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.zhi = 1; e.hiin = 1; push(e, iv, 1'($urandom), 1'b0);
      end
      3: begin
        e = blank(); e.rout = rb1; e.alu = alu_word(op); e.zin = 1;
        push(e, iv, 1'($urandom), 1'b0);
        e = blank(); e.zlo = 1; e.rin = ra1; push(e, iv, 1'($urandom), 1'b0);
      end
      6: begin
        e = blank(); e.ill = 1; push(e, iv, 1'($urandom), 1'b0);
      end
      default: push(blank(), iv, 1'($urandom), 1'b0);
    endcase
  endtask

  task automatic drain(input string name);
    cyc_t cy;
    cur_name = name;
    while (q.size() > 0) begin
      cy = q.pop_front();
      @(posedge clk);
      #1;
      ir = cy.ir; mem_ready = cy.mr; clr = cy.clr; cur_exp = cy.e;
      chk_en = 1'b1;
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pin %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] iv;
    logic [4:0]  op;
    int keep;

    add_reset(2);
    drain("reset");

    iv = 32'h4A920000;
    add_instr(iv, 0);
    pin("shl_len", q.size(), 6);
    pin("shl_t3_rout", q[3].e.rout, 16'h0004);
    pin("shl_t4_rout", q[4].e.rout, 16'h0010);
    pin("shl_t4_alu", q[4].e.alu, 12'h020);
    pin("shl_t5_rin", q[5].e.rin, 16'h0020);
    drain("shl");

    add_instr({5'd27, 27'h0}, 3);
    pin("wait_len", q.size(), 7);
    pin("wait_pcin_first", q[1].e.pcin, 1);
    pin("wait_pcin_later", q[2].e.pcin, 0);
    pin("wait_mdrread_last", q[4].e.mdrread, 1);
    drain("mem_wait_nop");

    add_instr({5'd15, 4'd3, 4'd1, 19'h0}, 1);
    pin("mul_len", q.size(), 8);
    pin("mul_t5_lo", {q[6].e.loin, q[6].e.zlo}, 2'b11);
    pin("mul_t6_hi", {q[7].e.hiin, q[7].e.zhi}, 2'b11);
    drain("mul");

    add_instr({5'd12, 4'd7, 4'd2, 19'h0}, 0);
    pin("addi_t4_cout", q[4].e.cout, 1);
    pin("addi_t4_rout", q[4].e.rout, 16'h0000);
    pin("addi_t4_alu", q[4].e.alu, 12'h001);
    pin("addi_t5_rin", q[5].e.rin, 16'h0080);
    drain("addi");

    add_instr({5'd31, 27'h5A5A5A5}, 0);
    pin("ill_pulse", q[3].e.ill, 1);
    drain("illegal");

    add_instr({5'd17, 4'd0, 4'd15, 19'h0}, 2);
    drain("neg_r0");

    // clr asserted for two cycles starting while the sequencer is in T4
    add_instr(32'h4A920000, 0);
    q = q[0:3];
    add_reset(2);
    drain("reset_mid_t4");
    add_instr({5'd4, 4'd1, 4'd2, 4'd3, 15'h0}, 0);
    drain("after_reset");

    add_instr({5'd28, 27'h0}, 1);
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      e = '0;
      push(e, {5'd28, 27'h0}, 1'($urandom), 1'b0);
    end
    add_reset(1);
    drain("halt");

    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd28) op = 5'd27;
      iv = {op, 27'($urandom)};
      add_instr(iv, $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        keep = $urandom_range(1, q.size() - 1);
        q = q[0:keep-1];
        add_reset($urandom_range(1, 2));
      end
      drain("random");
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
